// File: rtl/reg_file.sv
// Architectural register file with rename tags: committed values, per-register
// busy bit and producing ROB index, with commit-to-read bypass on lookups.
module reg_file #(
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_flag,
  input  logic               issue_valid,
  input  logic [4:0]         issue_dest,
  input  logic [ROB_LOG-1:0] issue_RobId,
  input  logic               commit_enable,
  input  logic [4:0]         commit_index,
  input  logic [ROB_LOG-1:0] commit_RobId,
  input  logic [31:0]        commit_value,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  output logic               rs1_busy,
  output logic [31:0]        rs1_value,
  output logic [ROB_LOG-1:0] rs1_RobId,
  output logic               rs2_busy,
  output logic [31:0]        rs2_value,
  output logic [ROB_LOG-1:0] rs2_RobId
);

  logic [31:0][31:0]        value_q, value_d;
  logic [31:0]              busy_q, busy_d;
  logic [31:0][ROB_LOG-1:0] tag_q, tag_d;

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (commit_enable && (commit_index != 5'd0)) begin
      value_d[commit_index] = commit_value;
      if (tag_q[commit_index] == commit_RobId)
        busy_d[commit_index] = 1'b0;
    end
    // Flush wins over issue; issue wins over a same-cycle commit's busy clear.
    if (jump_flag) begin
      busy_d = '0;
    end else if (issue_valid && (issue_dest != 5'd0)) begin
      busy_d[issue_dest] = 1'b1;
      tag_d[issue_dest]  = issue_RobId;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else if (rdy) begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    rs1_busy  = 1'b0;
    rs1_value = '0;
    rs1_RobId = '0;
    if (rs1 != 5'd0) begin
      rs1_RobId = tag_q[rs1];
      rs1_value = value_q[rs1];
      if (busy_q[rs1]) begin
        if (commit_enable && (commit_RobId == tag_q[rs1]))
          rs1_value = commit_value;
        else
          rs1_busy = 1'b1;
      end
    end
  end

  always_comb begin
    rs2_busy  = 1'b0;
    rs2_value = '0;
    rs2_RobId = '0;
    if (rs2 != 5'd0) begin
      rs2_RobId = tag_q[rs2];
      rs2_value = value_q[rs2];
      if (busy_q[rs2]) begin
        if (commit_enable && (commit_RobId == tag_q[rs2]))
          rs2_value = commit_value;
        else
          rs2_busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, bypass, flush, hold and reset.
module tb_reg_file;
  localparam int ROB_LOG = 4;

  logic               clk = 1'b0;
  logic               rst, rdy, jump_flag;
  logic               issue_valid;
  logic [4:0]         issue_dest;
  logic [ROB_LOG-1:0] issue_RobId;
  logic               commit_enable;
  logic [4:0]         commit_index;
  logic [ROB_LOG-1:0] commit_RobId;
  logic [31:0]        commit_value;
  logic [4:0]         rs1, rs2;
  logic               rs1_busy, rs2_busy;
  logic [31:0]        rs1_value, rs2_value;
  logic [ROB_LOG-1:0] rs1_RobId, rs2_RobId;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file #(.ROB_LOG(ROB_LOG)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_RobId(issue_RobId),
    .commit_enable(commit_enable), .commit_index(commit_index),
    .commit_RobId(commit_RobId), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs1_value(rs1_value), .rs1_RobId(rs1_RobId),
    .rs2_busy(rs2_busy), .rs2_value(rs2_value), .rs2_RobId(rs2_RobId)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jump_flag = 0; issue_valid = 0; issue_dest = 0; issue_RobId = 0;
    commit_enable = 0; commit_index = 0; commit_RobId = 0; commit_value = 0;
  endtask

  task automatic issue(input logic [4:0] d, input logic [ROB_LOG-1:0] id);
    issue_valid = 1; issue_dest = d; issue_RobId = id;
  endtask

  task automatic commit(input logic [4:0] idx, input logic [ROB_LOG-1:0] id, input logic [31:0] v);
    commit_enable = 1; commit_index = idx; commit_RobId = id; commit_value = v;
  endtask

  initial begin
    rst = 0; rdy = 1; rs1 = 0; rs2 = 0; idle();
    tick(); tick();
    rst = 1;

    // reset state
    rs1 = 5; rs2 = 0; #1;
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs1_val", rs1_value, 0);
    check("rst_rs2_busy", rs2_busy, 0);
    check("rst_rs2_val", rs2_value, 0);

    // issue then commit
    issue(3, 2); tick(); idle();
    rs1 = 3; #1;
    check("iss_busy", rs1_busy, 1);
    check("iss_tag", rs1_RobId, 2);
    commit(3, 2, 32'hDEADBEEF); #1;
    check("bypass3_busy", rs1_busy, 0);
    check("bypass3_val", rs1_value, 32'hDEADBEEF);
    tick(); idle(); #1;
    check("cmt3_busy", rs1_busy, 0);
    check("cmt3_val", rs1_value, 32'hDEADBEEF);

    // stale commit must not release a renamed register
    issue(4, 1); tick();
    issue(4, 5); tick(); idle();
    commit(4, 1, 7); tick(); idle();
    rs1 = 4; #1;
    check("stale_busy", rs1_busy, 1);
    check("stale_tag", rs1_RobId, 5);
    commit(4, 5, 9); tick(); idle(); #1;
    check("young_busy", rs1_busy, 0);
    check("young_val", rs1_value, 9);

    // combinational bypass on rs2
    issue(6, 3); tick(); idle();
    rs2 = 6; #1;
    check("pre_byp_busy", rs2_busy, 1);
    commit(6, 3, 32'h55); #1;
    check("byp_busy", rs2_busy, 0);
    check("byp_val", rs2_value, 32'h55);
    tick(); idle();

    // same-cycle commit and issue on one register: issue keeps it busy
    issue(10, 1); tick(); idle();
    commit(10, 1, 32'hAA); issue(10, 2); tick(); idle();
    rs1 = 10; #1;
    check("ci_busy", rs1_busy, 1);
    check("ci_tag", rs1_RobId, 2);
    commit(10, 2, 32'hBB); tick(); idle(); #1;
    check("ci_val", rs1_value, 32'hBB);

    // flush with commit and issue
    issue(1, 2); tick();
    issue(2, 4); tick(); idle();
    jump_flag = 1; commit(1, 2, 32'h10); issue(7, 6);
    tick(); idle();
    rs1 = 1; rs2 = 2; #1;
    check("fl_x1_busy", rs1_busy, 0);
    check("fl_x1_val", rs1_value, 32'h10);
    check("fl_x2_busy", rs2_busy, 0);
    rs1 = 7; #1;
    check("fl_x7_busy", rs1_busy, 0);

    // rdy low holds all state
    rdy = 0; issue(8, 7); commit(9, 0, 1); tick(); idle(); rdy = 1;
    rs1 = 8; rs2 = 9; #1;
    check("hold_x8_busy", rs1_busy, 0);
    check("hold_x9_val", rs2_value, 0);

    // reset clears committed values
    rst = 0; tick(); rst = 1;
    rs1 = 1; rs2 = 3; #1;
    check("rst2_x1_val", rs1_value, 0);
    check("rst2_x3_val", rs2_value, 0);
    check("rst2_x3_busy", rs2_busy, 0);

    // x0 ignores issue and commit
    issue(0, 3); tick(); idle();
    commit(0, 3, 32'h1234); tick(); idle();
    rs1 = 0; #1;
    check("x0_busy", rs1_busy, 0);
    check("x0_val", rs1_value, 0);
    check("x0_tag", rs1_RobId, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags.
- Sits directly downstream of the reorder buffer commit port and alongside the issue/decoder stage.
- Holds 32 x 32-bit committed register values plus a per-register busy bit and producing ROB index.
- Issue-time source lookups return either a ready value or the ROB tag to wait on; commits write values back and release tags.

Parameters:
ROB_LOG, 4, width of a ROB index (ROB holds 2^ROB_LOG entries)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-low reset; state cleared on a rising edge while rst==0
rdy  in  1  global ready; when 0 all state holds
jump_flag  in  1  ROB mispredict/flush pulse
issue_valid  in  1  an instruction is being issued this cycle
issue_dest  in  5  destination register of the issued instruction
issue_RobId  in  ROB_LOG  ROB entry allocated to the issued instruction
commit_enable  in  1  ROB commit writes a register this cycle
commit_index  in  5  committed destination register
commit_RobId  in  ROB_LOG  ROB entry being committed
commit_value  in  32  committed result
rs1  in  5  source register 1 index
rs2  in  5  source register 2 index
rs1_busy  out  1  rs1 value not yet available
rs1_value  out  32  rs1 value (valid when rs1_busy==0)
rs1_RobId  out  ROB_LOG  producer ROB entry (valid when rs1_busy==1)
rs2_busy  out  1  as rs1_busy, for rs2
rs2_value  out  32  as rs1_value, for rs2
rs2_RobId  out  ROB_LOG  as rs1_RobId, for rs2

Behaviour:
- State: value[0..31], busy[0..31], tag[0..31].
- Reset (rst==0 at edge): all value=0, busy=0, tag=0. Overrides rdy, issue, commit and flush.
- rdy==0: no state changes. Read outputs remain combinationally valid.
- Register x0:
  - Reads always give busy=0, value=0, RobId=0.
  - Issue and commit writes to index 0 are ignored.
- Commit (commit_enable, index!=0): value[index] <= commit_value.
  - busy[index] <= 0 only if tag[index]==commit_RobId and no same-cycle issue targets the same index.
- Issue (issue_valid, dest!=0, jump_flag==0): busy[dest] <= 1, tag[dest] <= issue_RobId.
  - Issue overrides a same-cycle commit's busy clear on that register.
- Commit and issue on the same register in the same cycle: value is written, busy stays 1, tag becomes issue_RobId.
- Flush (jump_flag==1):
  - All busy bits cleared.
  - The same-cycle commit write of value is still performed, because the ROB asserts commit and flush together for jumps.
  - Issue is ignored.
- Read (combinational, zero latency), per source rsN:
  - If rsN==0: busy=0, value=0.
  - Else if busy[rsN]==0: busy=0, value=value[rsN].
  - Else if commit_enable and commit_RobId==tag[rsN]: bypass, giving busy=0 and value=commit_value.
  - Else: busy=1, RobId=tag[rsN], value=value[rsN] (don't-care).
- Reads do not see a same-cycle issue. The issuing instruction's sources are resolved before its own destination is renamed.
- Tag compare is full ROB_LOG width; wrap-around of ROB indices needs no special handling. A stale tag is never matched, because the younger issue overwrote it.

Test Plan:
- Reset then read rs1=5, rs2=0 -> busy=0, value=0 on both ports.
- Issue dest=3, RobId=2, then commit index=3, RobId=2, value=0xDEADBEEF. Next cycle rs1=3 -> busy=0, value=0xDEADBEEF.
- Issue dest=4 RobId=1, then issue dest=4 RobId=5, then commit idx=4 RobId=1 val=7:
  - rs1=4 -> busy=1, RobId=5.
  - Commit RobId=5 val=9 -> rs1=4 gives busy=0, value=9.
- Bypass: x6 busy with tag 3. In the cycle commit RobId=3 val=0x55 is presented, rs2=6 -> busy=0, value=0x55 combinationally.
- Flush: x1 busy tag 2, x2 busy tag 4. Assert jump_flag with commit idx=1 RobId=2 val=0x10 and issue dest=7 RobId=6:
  - Next cycle x1 busy=0 value=0x10.
  - x2 busy=0.
  - x7 busy=0.
- rdy=0 with issue dest=8 and commit idx=9 val=1 -> no change. Then pulse rst=0 with rdy=1 -> all registers read 0 and not busy; issue dest=0 -> rs1=0 stays busy=0.
